door_direction_detector: RTL and testbench

Converts two raw infrared door beams (outer, inner) into single-cycle entry and exit events for the room occupancy counter. It sits directly upstream of the people counter: `enter_pulse` drives its increment input and `exit_pulse` drives its decrement input. Each beam is synchronised and debounced, then an ordered-sequence FSM decides the direction. Aborted or malformed passages generate no count.

---
 rtl/door_direction_detector_pkg.sv | 18 +
 rtl/door_direction_detector_beam_debouncer.sv | 52 +++++
 rtl/door_direction_detector.sv | 161 ++++++++++++++++
 tb/tb_door_direction_detector.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/door_direction_detector_pkg.sv
// Shared types and default constants for the smart-room door direction detector.
package smart_room_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IN_1,
    IN_2,
    IN_3,
    OUT_1,
    OUT_2,
    OUT_3,
    WAIT_CLEAR
  } door_state_t;

  localparam int DOOR_DEBOUNCE_DEFAULT = 16;
  localparam int DOOR_TIMEOUT_DEFAULT  = 1000;

endpackage

// File: rtl/door_direction_detector_beam_debouncer.sv
// Two-flop synchroniser plus stability counter for one raw infrared beam.
module beam_debouncer
  import smart_room_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DOOR_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic          filt_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The final differing cycle flips the filter instead of storing the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filtered = filt_q;

endmodule

// File: rtl/door_direction_detector.sv
// Ordered-sequence FSM turning debounced outer/inner beam levels into
// registered enter/exit/abort pulses for the occupancy counter.
module door_direction_detector
  import smart_room_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DOOR_DEBOUNCE_DEFAULT,
  parameter int TIMEOUT_CYCLES  = DOOR_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic beam_outer,
  input  logic beam_inner,
  output logic enter_pulse,
  output logic exit_pulse,
  output logic abort_pulse,
  output logic busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  door_state_t   state_q;
  door_state_t   state_d;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic          enter_q;
  logic          enter_d;
  logic          exit_q;
  logic          exit_d;
  logic          abort_q;
  logic          abort_d;
  logic          outer_f;
  logic          inner_f;
  logic [1:0]    pair;
  logic          in_passage;

  beam_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_outer (
    .clk      (clk),
    .reset    (reset),
    .raw      (beam_outer),
    .filtered (outer_f)
  );

  beam_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inner (
    .clk      (clk),
    .reset    (reset),
    .raw      (beam_inner),
    .filtered (inner_f)
  );

  assign pair       = {outer_f, inner_f};
  assign in_passage = (state_q != IDLE) && (state_q != WAIT_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      abort_q <= abort_d;
    end
  end

  // Any pair not named for a passage state is illegal and aborts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        case (pair)
          2'b10:   state_d = IN_1;
          2'b01:   state_d = OUT_1;
          2'b11:   state_d = WAIT_CLEAR;
          default: state_d = IDLE;
        endcase
      end
      IN_1: begin
        case (pair)
          2'b10:   state_d = IN_1;
          2'b11:   state_d = IN_2;
          2'b00:   state_d = IDLE;
          default: state_d = WAIT_CLEAR;
        endcase
      end
      IN_2: begin
        case (pair)
          2'b11:   state_d = IN_2;
          2'b01:   state_d = IN_3;
          2'b10:   state_d = IN_1;
          default: state_d = WAIT_CLEAR;
        endcase
      end
      IN_3: begin
        case (pair)
          2'b01:   state_d = IN_3;
          2'b00:   state_d = IDLE;
          2'b11:   state_d = IN_2;
          default: state_d = WAIT_CLEAR;
        endcase
      end
      OUT_1: begin
        case (pair)
          2'b01:   state_d = OUT_1;
          2'b11:   state_d = OUT_2;
          2'b00:   state_d = IDLE;
          default: state_d = WAIT_CLEAR;
        endcase
      end
      OUT_2: begin
        case (pair)
          2'b11:   state_d = OUT_2;
          2'b10:   state_d = OUT_3;
          2'b01:   state_d = OUT_1;
          default: state_d = WAIT_CLEAR;
        endcase
      end
      OUT_3: begin
        case (pair)
          2'b10:   state_d = OUT_3;
          2'b00:   state_d = IDLE;
          2'b11:   state_d = OUT_2;
          default: state_d = WAIT_CLEAR;
        endcase
      end
      WAIT_CLEAR: begin
        if (pair == 2'b00) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A legal move always wins over an expiring timeout in the same cycle.
    if (in_passage && (state_d == state_q) && (tmo_q == TMO_LAST)) begin
      state_d = WAIT_CLEAR;
    end

    if (!in_passage || (state_d != state_q)) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_comb begin
    enter_d = (state_q == IN_3)  && (state_d == IDLE);
    exit_d  = (state_q == OUT_3) && (state_d == IDLE);
    abort_d = (state_q != WAIT_CLEAR) && (state_d == WAIT_CLEAR);
    busy    = (state_q != IDLE);
  end

  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
  assign abort_pulse = abort_q;

endmodule

// File: tb/tb_door_direction_detector.sv
// Self-checking bench: segment table, hand-timed corner sequences and a
// randomized run against a path-position reference model.
module tb_door_direction_detector;

  localparam int D = 4;
  localparam int T = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic beam_outer = 1'b0;
  logic beam_inner = 1'b0;
  logic enter_pulse, exit_pulse, abort_pulse, busy;

  int errors = 0;
  int checks = 0;
  bit chk_model = 0;

  always #5 clk = ~clk;

  door_direction_detector #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .beam_outer  (beam_outer),
    .beam_inner  (beam_inner),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .abort_pulse (abort_pulse),
    .busy        (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a passage is a walk along the pair path
  // (0,0)->(1,0)->(1,1)->(0,1)->(0,0); exits walk it with the beams swapped.
  logic [1:0] path [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
  bit ho[$];
  bit hi[$];
  bit m_s1o = 0, m_s2o = 0, m_fo = 0;
  bit m_s1i = 0, m_s2i = 0, m_fi = 0;
  int m_pos = 0, m_dir = 0, m_stamp = 0, cyc = 0;
  bit m_wait = 0, m_enter = 0, m_exit = 0, m_abort = 0, m_busy = 0;
  logic [1:0] mp, mq;

  function automatic bit all_differ(input bit h[$], input bit f);
    if (h.size() < D) return 1'b0;
    foreach (h[k]) if (h[k] == f) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_enter = 0;
    m_exit  = 0;
    m_abort = 0;
    if (reset) begin
      m_s1o = 0; m_s2o = 0; m_fo = 0;
      m_s1i = 0; m_s2i = 0; m_fi = 0;
      ho.delete();
      hi.delete();
      m_pos  = 0;
      m_wait = 0;
    end else begin
      mp = {m_fo, m_fi};
      if (m_wait) begin
        if (mp == 2'b00) m_wait = 0;
      end else if (m_pos == 0) begin
        if (mp == 2'b10) begin m_dir = 0; m_pos = 1; m_stamp = cyc; end
        else if (mp == 2'b01) begin m_dir = 1; m_pos = 1; m_stamp = cyc; end
        else if (mp == 2'b11) begin m_wait = 1; m_abort = 1; end
      end else begin
        mq = m_dir ? {mp[0], mp[1]} : mp;
        if (mq == path[m_pos+1]) begin
          if (m_pos == 3) begin
            m_pos = 0;
            if (m_dir != 0) m_exit = 1; else m_enter = 1;
          end else begin
            m_pos++;
          end
          m_stamp = cyc;
        end else if (mq == path[m_pos-1]) begin
          m_pos--;
          m_stamp = cyc;
        end else if (mq != path[m_pos] || (cyc - m_stamp) >= T) begin
          m_pos  = 0;
          m_wait = 1;
          m_abort = 1;
        end
      end
      // Filtered level follows once the last D synchronised samples all disagree.
      ho.push_back(m_s2o);
      if (ho.size() > D) void'(ho.pop_front());
      if (all_differ(ho, m_fo)) m_fo = m_s2o;
      hi.push_back(m_s2i);
      if (hi.size() > D) void'(hi.pop_front());
      if (all_differ(hi, m_fi)) m_fi = m_s2i;
      m_s2o = m_s1o; m_s1o = beam_outer;
      m_s2i = m_s1i; m_s1i = beam_inner;
    end
    m_busy = (m_pos != 0) || m_wait;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (chk_model) begin
      check("model_enter", int'(enter_pulse), int'(m_enter));
      check("model_exit",  int'(exit_pulse),  int'(m_exit));
      check("model_abort", int'(abort_pulse), int'(m_abort));
      check("model_busy",  int'(busy),        int'(m_busy));
    end
  endtask

  task automatic apply(input bit o, input bit i, input int n,
                       output int ne, output int nx, output int na,
                       output bit be, output bit bs);
    beam_outer = o;
    beam_inner = i;
    ne = 0; nx = 0; na = 0; bs = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      ne += int'(enter_pulse);
      nx += int'(exit_pulse);
      na += int'(abort_pulse);
      if (busy) bs = 1;
    end
    be = busy;
  endtask

  typedef struct {
    bit o;
    bit i;
    int n;
    int enter;
    int exit_n;
    int abort;
    bit busy_end;
    bit busy_seen;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ne, nx, na, first, cnt, busy_at;
    bit be, bs;

    // Segments: raw pair, cycles held, pulses seen, busy at end, busy seen.
    vecs.push_back('{1, 0, 10, 0, 0, 0, 1, 1});  // clean entry
    vecs.push_back('{1, 1, 10, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 1, 10, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 0, 10, 1, 0, 0, 0, 1});
    vecs.push_back('{0, 1, 10, 0, 0, 0, 1, 1});  // clean exit
    vecs.push_back('{1, 1, 10, 0, 0, 0, 1, 1});
    vecs.push_back('{1, 0, 10, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 0, 10, 0, 1, 0, 0, 1});
    vecs.push_back('{1, 0, 10, 0, 0, 0, 1, 1});  // back-to-back entry
    vecs.push_back('{1, 1, 10, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 1, 10, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 0, 10, 1, 0, 0, 0, 1});
    vecs.push_back('{1, 0,  3, 0, 0, 0, 0, 0});  // glitches
    vecs.push_back('{0, 0, 10, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0,  3, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 10, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 10, 0, 0, 0, 1, 1});  // back-out
    vecs.push_back('{0, 0, 10, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 10, 0, 0, 0, 1, 1});  // timeout in IN_2
    vecs.push_back('{1, 1, 60, 0, 0, 1, 1, 1});
    vecs.push_back('{0, 0, 10, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 10, 0, 0, 0, 1, 1});  // illegal jump
    vecs.push_back('{0, 1, 10, 0, 0, 1, 1, 1});
    vecs.push_back('{0, 0, 10, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 10, 0, 0, 1, 1, 1});  // both blocked from IDLE
    vecs.push_back('{0, 0, 10, 0, 0, 0, 0, 1});

    reset = 1'b1;
    tick();
    tick();
    check("reset_enter", int'(enter_pulse), 0);
    check("reset_exit",  int'(exit_pulse),  0);
    check("reset_abort", int'(abort_pulse), 0);
    check("reset_busy",  int'(busy),        0);
    reset = 1'b0;
    chk_model = 1;

    foreach (vecs[v]) begin
      apply(vecs[v].o, vecs[v].i, vecs[v].n, ne, nx, na, be, bs);
      check($sformatf("vec%0d_enter", v), ne, vecs[v].enter);
      check($sformatf("vec%0d_exit", v), nx, vecs[v].exit_n);
      check($sformatf("vec%0d_abort", v), na, vecs[v].abort);
      check($sformatf("vec%0d_busy_end", v), int'(be), int'(vecs[v].busy_end));
      check($sformatf("vec%0d_busy_seen", v), int'(bs), int'(vecs[v].busy_seen));
    end

    // Entry pulse D+3 cycles after the last raw edge, with busy dropping together.
    apply(1, 0, 10, ne, nx, na, be, bs);
    apply(1, 1, 10, ne, nx, na, be, bs);
    apply(0, 1, 10, ne, nx, na, be, bs);
    beam_outer = 0;
    beam_inner = 0;
    first = -1; cnt = 0; busy_at = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (enter_pulse) begin
        cnt++;
        if (first < 0) begin first = k; busy_at = int'(busy); end
      end
    end
    check("entry_latency", first, D + 3);
    check("entry_count", cnt, 1);
    check("entry_busy_clear", busy_at, 0);

    // Abort exactly T cycles after IN_2 is entered (D+3 after inner rises).
    apply(1, 0, 10, ne, nx, na, be, bs);
    beam_inner = 1;
    first = -1; cnt = 0;
    for (int k = 1; k <= 75; k++) begin
      tick();
      if (abort_pulse) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    check("timeout_latency", first, D + 3 + T);
    check("timeout_count", cnt, 1);
    apply(0, 0, 10, ne, nx, na, be, bs);
    check("timeout_release_enter", ne, 0);
    check("timeout_release_busy", int'(be), 0);

    // Reset while in IN_3: passage lost, blocked inner beam restarts as OUT_1.
    apply(1, 0, 10, ne, nx, na, be, bs);
    apply(1, 1, 10, ne, nx, na, be, bs);
    apply(0, 1, 10, ne, nx, na, be, bs);
    reset = 1'b1;
    tick();
    check("midreset_enter", int'(enter_pulse), 0);
    check("midreset_exit",  int'(exit_pulse),  0);
    check("midreset_abort", int'(abort_pulse), 0);
    check("midreset_busy",  int'(busy),        0);
    reset = 1'b0;
    first = -1; cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      cnt += int'(enter_pulse) + int'(exit_pulse) + int'(abort_pulse);
      if (busy && first < 0) first = k;
    end
    check("midreset_out1_latency", first, D + 3);
    check("midreset_no_pulse", cnt, 0);
    apply(0, 0, 10, ne, nx, na, be, bs);
    check("midreset_backout_enter", ne, 0);
    check("midreset_backout_exit", nx, 0);
    check("midreset_backout_abort", na, 0);
    check("midreset_backout_busy", int'(be), 0);

    // Randomized segments, including long holds and occasional resets.
    for (int s = 0; s < 250; s++) begin
      int r;
      int n;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        beam_outer = 1'($urandom_range(0, 1));
        beam_inner = 1'($urandom_range(0, 1));
        n = (r == 1) ? 60 : $urandom_range(1, 12);
        repeat (n) tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
